// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Packet layout is {op, addr, data}, MSB first.
package spi_ctrl_pkg;

  localparam int ADDR_WIDTH   = 14;
  localparam int DATA_WIDTH   = 24;
  localparam int PACKET_WIDTH = 2 + ADDR_WIDTH + DATA_WIDTH;

  localparam int OP_LSB   = ADDR_WIDTH + DATA_WIDTH;
  localparam int ADDR_LSB = DATA_WIDTH;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_WRITE     = 2'b01,
    OP_READ      = 2'b10,
    OP_WRITE_INC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_MEM_REQ   = 3'd2,
    ST_MEM_RDATA = 3'd3,
    ST_LOAD      = 3'd4
  } state_e;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Decodes packets from the SPI serdes into register-memory accesses and
// builds the response word the serdes shifts back out.
module spi_reg_ctrl #(
  parameter int ADDR_WIDTH   = spi_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = spi_ctrl_pkg::DATA_WIDTH,
  parameter int PACKET_WIDTH = spi_ctrl_pkg::PACKET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] rxData,
  input  logic                    dataReady,
  output logic [PACKET_WIDTH-1:0] txData,
  output logic                    load,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    overrun,
  output logic [15:0]             pkt_count
);

  import spi_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_e                state, state_next;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;

  // A packet is only taken when the FSM can start on it next cycle
  assign accept  = dataReady && (state == ST_IDLE || state == ST_LOAD);
  assign load    = (state == ST_LOAD);
  assign mem_req = (state == ST_MEM_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (dataReady) state_next = ST_DECODE;
      ST_DECODE:    state_next = (op_q == OP_NOP) ? ST_LOAD : ST_MEM_REQ;
      ST_MEM_REQ:   if (mem_gnt) state_next = mem_we ? ST_LOAD : ST_MEM_RDATA;
      ST_MEM_RDATA: state_next = ST_LOAD;
      ST_LOAD:      state_next = dataReady ? ST_DECODE : ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_NOP;
      addr_q    <= '0;
      data_q    <= '0;
      ptr       <= '0;
      txData    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overrun   <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_e'(rxData[OP_LSB +: 2]);
        addr_q    <= rxData[ADDR_LSB +: ADDR_WIDTH];
        data_q    <= rxData[DATA_LSB +: DATA_WIDTH];
        pkt_count <= pkt_count + 16'd1;
      end
      if (dataReady && !accept) overrun <= 1'b1;

      // Memory-side outputs are fixed in DECODE so they hold for all of MEM_REQ
      case (state)
        ST_DECODE: begin
          case (op_q)
            OP_WRITE: begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_q;
              mem_wdata <= data_q;
              ptr       <= addr_q + ADDR_ONE;
            end
            OP_READ: begin
              mem_we    <= 1'b0;
              mem_addr  <= addr_q;
              ptr       <= addr_q + ADDR_ONE;
            end
            OP_WRITE_INC: begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= data_q;
              ptr       <= ptr + ADDR_ONE;
            end
            default: txData <= {OP_NOP, {ADDR_WIDTH{1'b0}}, {(DATA_WIDTH-1){1'b0}}, overrun};
          endcase
        end
        ST_MEM_REQ:   if (mem_gnt && mem_we) txData <= {op_q, mem_addr, mem_wdata};
        ST_MEM_RDATA: txData <= {op_q, mem_addr, mem_rdata};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: the bench plays the memory side and
// checks handshake timing, response words, pointer and overrun behaviour.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] rxData;
  logic        dataReady;
  logic [39:0] txData;
  logic        load;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_gnt;
  logic [23:0] mem_rdata;
  logic        overrun;
  logic [15:0] pkt_count;

  int checks   = 0;
  int failures = 0;
  int expCount = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .rxData(rxData), .dataReady(dataReady),
    .txData(txData), .load(load), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .overrun(overrun), .pkt_count(pkt_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One full transaction; dropAt >= 0 injects an extra dataReady in that MEM_REQ cycle
  task automatic applyStimulus(input string tag, input logic [39:0] pkt, input int gntDelay,
                               input int dropAt, input logic [23:0] rdata,
                               input logic [13:0] expAddr, input logic [39:0] expTx);
    logic [1:0] op;
    op = pkt[39:38];
    @(negedge clk);
    rxData = pkt;
    dataReady = 1'b1;
    expCount++;
    @(negedge clk);
    dataReady = 1'b0;
    checkOutput({tag, "_decode_noload"}, 64'(load), 64'd0);
    if (op != 2'b00) begin
      for (int i = 0; i <= gntDelay; i++) begin
        @(negedge clk);
        dataReady = 1'b0;
        checkOutput({tag, "_req"}, 64'(mem_req), 64'd1);
        checkOutput({tag, "_addr"}, 64'(mem_addr), 64'(expAddr));
        checkOutput({tag, "_we"}, 64'(mem_we), (op == 2'b10) ? 64'd0 : 64'd1);
        if (op != 2'b10) checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(pkt[23:0]));
        if (i == dropAt) begin
          rxData = 40'hFF_FFFF_FFFF;
          dataReady = 1'b1;
        end
        if (i == gntDelay) mem_gnt = 1'b1;
      end
      @(negedge clk);
      mem_gnt = 1'b0;
      dataReady = 1'b0;
      checkOutput({tag, "_req_drop"}, 64'(mem_req), 64'd0);
      if (op == 2'b10) begin
        mem_rdata = rdata;
        checkOutput({tag, "_rdata_noload"}, 64'(load), 64'd0);
        @(negedge clk);
        mem_rdata = 24'h0;
      end
    end else begin
      @(negedge clk);
    end
    checkOutput({tag, "_load"}, 64'(load), 64'd1);
    checkOutput({tag, "_txdata"}, 64'(txData), 64'(expTx));
    @(negedge clk);
    checkOutput({tag, "_load_pulse"}, 64'(load), 64'd0);
    checkOutput({tag, "_txhold"}, 64'(txData), 64'(expTx));
    checkOutput({tag, "_pkt_count"}, 64'(pkt_count), 64'(16'(expCount)));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rxData = '0;
    dataReady = 1'b0;
    mem_gnt = 1'b0;
    mem_rdata = '0;
    #12;
    checkOutput("rst_txdata", 64'(txData), 64'd0);
    checkOutput("rst_load", 64'(load), 64'd0);
    checkOutput("rst_req", 64'(mem_req), 64'd0);
    checkOutput("rst_we", 64'(mem_we), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    checkOutput("rst_count", 64'(pkt_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("write", 40'h40_10AB_CDEF, 3, -1, 24'h0, 14'h0010, 40'h40_10AB_CDEF);
    applyStimulus("read", 40'h80_1000_0000, 1, -1, 24'h123456, 14'h0010, 40'h80_1012_3456);
    applyStimulus("inc_ptr", {2'b11, 14'h2222, 24'h000111}, 0, -1, 24'h0, 14'h0011,
                  {2'b11, 14'h0011, 24'h000111});

    applyStimulus("wr_top", {2'b01, 14'h3FFF, 24'hAAAAAA}, 0, -1, 24'h0, 14'h3FFF,
                  {2'b01, 14'h3FFF, 24'hAAAAAA});
    applyStimulus("inc_wrap0", {2'b11, 14'h0000, 24'h000001}, 2, -1, 24'h0, 14'h0000,
                  {2'b11, 14'h0000, 24'h000001});
    applyStimulus("inc_wrap1", {2'b11, 14'h0000, 24'h000002}, 0, -1, 24'h0, 14'h0001,
                  {2'b11, 14'h0001, 24'h000002});

    checkOutput("ovr_clear_before", 64'(overrun), 64'd0);
    applyStimulus("ovr_write", {2'b01, 14'h0020, 24'h00BEEF}, 3, 1, 24'h0, 14'h0020,
                  {2'b01, 14'h0020, 24'h00BEEF});
    checkOutput("ovr_set", 64'(overrun), 64'd1);
    applyStimulus("ovr_nop", 40'h00_0000_0000, 0, -1, 24'h0, 14'h0, 40'h00_0000_0001);

    // Second NOP presented in the first one's load cycle
    @(negedge clk);
    rxData = 40'h0;
    dataReady = 1'b1;
    expCount++;
    @(negedge clk);
    dataReady = 1'b0;
    @(negedge clk);
    checkOutput("b2b_load_a", 64'(load), 64'd1);
    dataReady = 1'b1;
    expCount++;
    @(negedge clk);
    dataReady = 1'b0;
    checkOutput("b2b_decode_b", 64'(load), 64'd0);
    checkOutput("b2b_count", 64'(pkt_count), 64'(16'(expCount)));
    @(negedge clk);
    checkOutput("b2b_load_b", 64'(load), 64'd1);
    checkOutput("b2b_tx", 64'(txData), 64'd1);
    checkOutput("b2b_overrun_hold", 64'(overrun), 64'd1);
    @(negedge clk);
    checkOutput("b2b_load_end", 64'(load), 64'd0);

    // Reset while a write is waiting for its grant
    @(negedge clk);
    rxData = {2'b01, 14'h0123, 24'h555555};
    dataReady = 1'b1;
    @(negedge clk);
    dataReady = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_req_before", 64'(mem_req), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_req", 64'(mem_req), 64'd0);
    checkOutput("rstmid_load", 64'(load), 64'd0);
    checkOutput("rstmid_we", 64'(mem_we), 64'd0);
    checkOutput("rstmid_addr", 64'(mem_addr), 64'd0);
    checkOutput("rstmid_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rstmid_txdata", 64'(txData), 64'd0);
    checkOutput("rstmid_overrun", 64'(overrun), 64'd0);
    checkOutput("rstmid_count", 64'(pkt_count), 64'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstmid_no_load", 64'(load), 64'd0);
      checkOutput("rstmid_no_req", 64'(mem_req), 64'd0);
    end
    mem_gnt = 1'b0;
    expCount = 0;

    applyStimulus("inc_after_rst", {2'b11, 14'h1234, 24'h0F0F0F}, 1, -1, 24'h0, 14'h0000,
                  {2'b11, 14'h0000, 24'h0F0F0F});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
